// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter: raster-order pixels in, one filtered pixel out per input pixel.
// Build macro MEDIAN_BORDER_ZERO_EN: border outputs forced to zero instead of passing the centre pixel.
//
// state | meaning
// IDLE  | waiting for start, input closed
// RUN   | accepting frame pixels, outputs trail inputs by COLS+1 pixels
// FLUSH | input closed, draining the last COLS+1 outputs from the line buffers
module median_filter_stream #(
    parameter int WIDTH = 8,
    parameter int COLS  = 554,
    parameter int ROWS  = 430
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = $clog2(ROWS + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(ROWS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state, state_nx;

    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;

    logic [WIDTH-1:0] lb1 [COLS];
    logic [WIDTH-1:0] lb2 [COLS];
    logic [WIDTH-1:0] col_new [3];
    logic [WIDTH-1:0] col_p1 [3];
    logic [WIDTH-1:0] col_p2 [3];
    logic [WIDTH-1:0] win [9];
    logic [WIDTH-1:0] median, result;

    logic slot_free, accept, step, primed, emit, last_in, out_hs, border;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == RUN) && slot_free;
    assign accept    = in_ready && in_valid;
    // FLUSH keeps stepping the window with phantom pixels until every output is emitted
    assign step      = accept || ((state == FLUSH) && slot_free && (out_row != ROW_END));
    assign primed    = (in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0));
    assign emit      = step && primed;
    assign last_in   = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign out_hs    = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign border    = (out_row == '0) || (out_row == ROW_LAST) ||
                       (out_col == '0) || (out_col == COL_LAST);

    // Newest column holds rows in_row-2, in_row-1, in_row; the centre of the pending
    // output is always the middle of the previous column, even across row wraps.
    always_comb begin
        col_new[0] = lb2[in_col];
        col_new[1] = lb1[in_col];
        col_new[2] = in_data;
        for (int i = 0; i < 3; i++) begin
            win[i]     = col_p2[i];
            win[i + 3] = col_p1[i];
            win[i + 6] = col_new[i];
        end
    end

    always_comb begin
        logic [3:0] n_lt;
        logic [3:0] n_eq;
        logic       found;
        median = '0;
        found  = 1'b0;
        n_lt   = '0;
        n_eq   = '0;
        for (int i = 0; i < 9; i++) begin
            n_lt = '0;
            n_eq = '0;
            for (int j = 0; j < 9; j++) begin
                if (win[j] < win[i]) begin
                    n_lt = n_lt + 4'd1;
                end else if (win[j] == win[i]) begin
                    n_eq = n_eq + 4'd1;
                end
            end
            if (!found && (n_lt <= 4'd4) && ((n_lt + n_eq) >= 4'd5)) begin
                median = win[i];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        result = median;
        if (border) begin
`ifdef MEDIAN_BORDER_ZERO_EN
            result = '0;
`else
            result = col_p1[1];
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && last_in) state_nx = FLUSH;
            FLUSH:   if (out_hs && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Line buffers are never read before being rewritten in the current frame, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[in_col] <= in_data;
            lb2[in_col] <= lb1[in_col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_row    <= '0;
            in_col    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                col_p1[i] <= '0;
                col_p2[i] <= '0;
            end
        end else begin
            state <= state_nx;
            done  <= (state == FLUSH) && out_hs && out_last;

            if ((state == IDLE) && start) begin
                in_row  <= '0;
                in_col  <= '0;
                out_row <= '0;
                out_col <= '0;
            end

            if (step) begin
                col_p2 <= col_p1;
                col_p1 <= col_new;
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_last  <= (out_row == ROW_LAST) && (out_col == COL_LAST);
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Self-checking bench for median_filter_stream: a 5x4 and a 6x5 instance, checked against
// a sort-based 3x3 median model of the whole frame; honours MEDIAN_BORDER_ZERO_EN.
module tb_median_filter_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       rdy_a, ov_a, ol_a, busy_a, done_a;
    logic [7:0] od_a;
    logic       rdy_b, ov_b, ol_b, busy_b, done_b;
    logic [7:0] od_b;

    median_filter_stream #(.WIDTH(8), .COLS(5), .ROWS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
        .out_last(ol_a), .busy(busy_a), .done(done_a)
    );

    median_filter_stream #(.WIDTH(8), .COLS(6), .ROWS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready),
        .out_last(ol_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    bit         sel;
    logic       m_in_ready, m_out_valid, m_out_last, m_busy, m_done;
    logic [7:0] m_out_data;
    assign m_in_ready  = sel ? rdy_b  : rdy_a;
    assign m_out_valid = sel ? ov_b   : ov_a;
    assign m_out_last  = sel ? ol_b   : ol_a;
    assign m_out_data  = sel ? od_b   : od_a;
    assign m_busy      = sel ? busy_b : busy_a;
    assign m_done      = sel ? done_b : done_a;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int img   [64];
    int exp_q [64];
    int hs_cyc[64];
    int n_cols, n_rows, n_pix;

    bit checking = 0;
    bit nostall  = 1;
    bit bp_mode  = 0;
    int out_idx, in_seen, done_cnt, last_out_cyc, last_hs_cyc;
    bit hold_pending = 0;
    int held_data, held_last;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void build_expected();
        int w[9];
        int t;
        for (int k = 0; k < n_pix; k++) begin
            int r, c;
            r = k / n_cols;
            c = k % n_cols;
            if (r == 0 || r == n_rows - 1 || c == 0 || c == n_cols - 1) begin
`ifdef MEDIAN_BORDER_ZERO_EN
                exp_q[k] = 0;
`else
                exp_q[k] = img[k];
`endif
            end else begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        w[(dr + 1) * 3 + dc + 1] = img[(r + dr) * n_cols + c + dc];
                for (int a = 0; a < 9; a++)
                    for (int b = 0; b < 8 - a; b++)
                        if (w[b] > w[b + 1]) begin
                            t = w[b]; w[b] = w[b + 1]; w[b + 1] = t;
                        end
                exp_q[k] = w[4];
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else if (checking) begin
            if (in_valid && m_in_ready && in_seen < 64) begin
                hs_cyc[in_seen] = cyc;
                in_seen++;
            end
            if (hold_pending) begin
                chk("hold_valid", int'(m_out_valid), 1);
                chk("hold_data", int'(m_out_data), held_data);
                chk("hold_last", int'(m_out_last), held_last);
            end
            hold_pending = 1'b0;
            if (m_out_valid) begin
                if (nostall && out_idx < n_pix) begin
                    if (out_idx + n_cols + 1 < n_pix)
                        chk("latency", cyc, hs_cyc[out_idx + n_cols + 1] + 1);
                    else
                        chk("flush_rate", cyc, last_out_cyc + 1);
                    last_out_cyc = cyc;
                end
                if (out_ready) begin
                    if (out_idx < n_pix) begin
                        chk("data", int'(m_out_data), exp_q[out_idx]);
                        chk("last", int'(m_out_last), int'(out_idx == n_pix - 1));
                    end else begin
                        chk("extra_output_index", out_idx, n_pix - 1);
                    end
                    if (m_out_last) last_hs_cyc = cyc;
                    out_idx++;
                end else begin
                    hold_pending = 1'b1;
                    held_data    = int'(m_out_data);
                    held_last    = int'(m_out_last);
                end
            end
            if (m_done) begin
                done_cnt++;
                chk("done_timing", cyc, last_hs_cyc + 1);
                chk("busy_at_done", int'(m_busy), 0);
            end
        end
    end

    task automatic begin_frame(input bit s, input bit bp);
        sel          = s;
        bp_mode      = bp;
        nostall      = !bp;
        out_idx      = 0;
        in_seen      = 0;
        done_cnt     = 0;
        last_out_cyc = -10;
        last_hs_cyc  = -10;
        hold_pending = 1'b0;
        build_expected();
        checking     = 1'b1;
        @(posedge clk); #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic feed(input int count, input bit bp);
        int j = 0;
        int guard = 0;
        bit hs;
        while (j < count && guard < 5000) begin
            in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 8'(img[j]);
            @(negedge clk);
            hs = in_valid && m_in_ready;
            @(posedge clk); #1;
            if (hs) j++;
            guard++;
        end
        in_valid = 1'b0;
        chk("inputs_accepted", j, count);
    endtask

    task automatic finish_frame();
        int guard = 0;
        while (done_cnt == 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("output_count", out_idx, n_pix);
        chk("done_count", done_cnt, 1);
        checking = 1'b0;
        bp_mode  = 1'b0;
    endtask

    task automatic set_size(input int c, input int r);
        n_cols = c;
        n_rows = r;
        n_pix  = c * r;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start_a   = 1'b1;
        start_b   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_a", int'(rdy_a), 0);
        chk("rst_out_valid_a", int'(ov_a), 0);
        chk("rst_out_data_a", int'(od_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_in_ready_b", int'(rdy_b), 0);
        chk("rst_out_valid_b", int'(ov_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // constant frame 5x4
        set_size(5, 4);
        for (int k = 0; k < 20; k++) img[k] = 'h40;
        begin_frame(1'b0, 1'b0);
        chk("model_const_interior", exp_q[6], 'h40);
`ifdef MEDIAN_BORDER_ZERO_EN
        chk("model_const_border", exp_q[0], 'h00);
`else
        chk("model_const_border", exp_q[0], 'h40);
`endif
        feed(20, 1'b0);
        finish_frame();

        // impulse 5x4
        for (int k = 0; k < 20; k++) img[k] = 'h10;
        img[12] = 'hFF;
        begin_frame(1'b0, 1'b0);
        chk("model_impulse_centre", exp_q[12], 'h10);
        chk("model_impulse_neighbour", exp_q[11], 'h10);
        feed(20, 1'b0);
        finish_frame();

        // ramp 6x5
        set_size(6, 5);
        for (int k = 0; k < 30; k++) img[k] = k;
        begin_frame(1'b1, 1'b0);
        chk("model_ramp_7", exp_q[7], 7);
        chk("model_ramp_14", exp_q[14], 14);
        feed(30, 1'b0);
        finish_frame();

        // ramp 6x5 under random input and output backpressure
        begin_frame(1'b1, 1'b1);
        feed(30, 1'b1);
        finish_frame();

        // abort after 7 inputs, then a clean ramp frame
        begin_frame(1'b1, 1'b0);
        feed(7, 1'b0);
        checking = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_out_valid", int'(ov_b), 0);
        chk("abort_busy", int'(busy_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        begin_frame(1'b1, 1'b0);
        feed(30, 1'b0);
        finish_frame();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
